// File: rtl/pwm_chaser_pkg.sv
// Shared types and helpers for the PWM LED chaser.
// Mode encoding matches the top-level mode switches; the reserved code behaves as HOLD.
package pwm_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE  = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_HOLD    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } breathe_e;

  function automatic logic [31:0] sat_duty(input logic [31:0] value, input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow-buffered duty plus a registered compare against the shared period counter.
// The shadow only reloads on the period wrap so a duty change never cuts a period short.
module pwm_channel #(
  parameter int                  PWM_BITS   = 7,
  parameter logic [PWM_BITS-1:0] RESET_DUTY = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] period,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  logic [PWM_BITS-1:0] active_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_duty <= RESET_DUTY;
      pwm         <= 1'b0;
    end else begin
      if (wrap) begin
        active_duty <= duty;
      end
      pwm <= en && (period < active_duty);
    end
  end

endmodule

// File: rtl/pwm_chaser.sv
// N-channel PWM LED sequencer: rotating, breathing or frozen duty pattern with a host write port.
// Counters, duty ring and breathe ramp live here; per-channel compare lives in pwm_channel.
module pwm_chaser
  import pwm_chaser_pkg::*;
#(
  parameter int N_CH       = 10,
  parameter int PWM_BITS   = 7,
  parameter int PWM_PERIOD = 100,
  parameter int STEP_TICKS = 25000000,
  parameter int LEVEL_STEP = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sentido,
  input  logic [1:0]               mode,
  input  logic                     wr_en,
  input  logic [$clog2(N_CH)-1:0]  wr_ch,
  input  logic [PWM_BITS-1:0]      wr_duty,
  output logic [N_CH-1:0]          pwm_out,
  output logic                     step_pulse,
  output logic [$clog2(N_CH)-1:0]  head_idx
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  localparam logic [PWM_BITS-1:0] PERIOD_LAST = PWM_BITS'(PWM_PERIOD - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_TICKS - 1);
  localparam logic [CH_W-1:0]     CH_LAST     = CH_W'(N_CH - 1);

  function automatic logic [PWM_BITS-1:0] reset_duty(input int idx);
    return PWM_BITS'(sat_duty(32'(idx * LEVEL_STEP), 32'(PWM_PERIOD)));
  endfunction

  logic [PWM_BITS-1:0] period_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                wrap;
  logic                tick;

  logic [PWM_BITS-1:0] duty     [N_CH];
  logic [PWM_BITS-1:0] duty_nxt [N_CH];
  logic [PWM_BITS-1:0] level, level_nxt;
  breathe_e            br_state, br_state_nxt;
  logic [CH_W-1:0]     head_nxt;
  logic [31:0]         level_up, level_dn;
  mode_e               mode_sel;

  assign wrap       = en && (period_cnt == PERIOD_LAST);
  assign tick       = en && (step_cnt == STEP_LAST);
  assign step_pulse = tick;
  assign mode_sel   = mode_e'(mode);

  // Both counters freeze together while disabled so the pattern resumes in phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      step_cnt   <= '0;
    end else if (en) begin
      period_cnt <= wrap ? '0 : period_cnt + 1'b1;
      step_cnt   <= tick ? '0 : step_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        duty[i] <= reset_duty(i);
      end
      level    <= '0;
      br_state <= BR_UP;
      head_idx <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        duty[i] <= duty_nxt[i];
      end
      level    <= level_nxt;
      br_state <= br_state_nxt;
      head_idx <= head_nxt;
    end
  end

  // Step action first, then the host write overrides its own channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty_nxt[i] = duty[i];
    end
    level_nxt    = level;
    br_state_nxt = br_state;
    head_nxt     = head_idx;
    level_up     = sat_duty(32'(level) + 32'(LEVEL_STEP), 32'(PWM_PERIOD));
    level_dn     = (32'(level) > 32'(LEVEL_STEP)) ? 32'(level) - 32'(LEVEL_STEP) : 32'd0;

    if (tick) begin
      case (mode_sel)
        MODE_ROTATE: begin
          if (sentido) begin
            for (int i = 0; i < N_CH; i++) begin
              duty_nxt[i] = duty[(i + N_CH - 1) % N_CH];
            end
            head_nxt = (head_idx == CH_LAST) ? '0 : head_idx + 1'b1;
          end else begin
            for (int i = 0; i < N_CH; i++) begin
              duty_nxt[i] = duty[(i + 1) % N_CH];
            end
            head_nxt = (head_idx == '0) ? CH_LAST : head_idx - 1'b1;
          end
        end
        MODE_BREATHE: begin
          if (br_state == BR_UP) begin
            level_nxt = PWM_BITS'(level_up);
            if (level_up == 32'(PWM_PERIOD)) begin
              br_state_nxt = BR_DOWN;
            end
          end else begin
            level_nxt = PWM_BITS'(level_dn);
            if (level_dn == 32'd0) begin
              br_state_nxt = BR_UP;
            end
          end
          for (int i = 0; i < N_CH; i++) begin
            duty_nxt[i] = level_nxt;
          end
        end
        default: begin
        end
      endcase
    end

    if (wr_en && (32'(wr_ch) < 32'(N_CH))) begin
      duty_nxt[wr_ch] = PWM_BITS'(sat_duty(32'(wr_duty), 32'(PWM_PERIOD)));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .RESET_DUTY (reset_duty(g))
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .wrap   (wrap),
      .period (period_cnt),
      .duty   (duty[g]),
      .pwm    (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_chaser.sv
// Randomised and directed bench for pwm_chaser against a behavioural model of the LED sequencer.
module tb_pwm_chaser;

  localparam int N_CH       = 4;
  localparam int PWM_BITS   = 4;
  localparam int PWM_PERIOD = 10;
  localparam int STEP_TICKS = 5;
  localparam int LEVEL_STEP = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                sentido;
  logic [1:0]          mode;
  logic                wr_en;
  logic [1:0]          wr_ch;
  logic [PWM_BITS-1:0] wr_duty;
  logic [N_CH-1:0]     pwm_out;
  logic                step_pulse;
  logic [1:0]          head_idx;

  always #5 clk = ~clk;

  pwm_chaser #(
    .N_CH       (N_CH),
    .PWM_BITS   (PWM_BITS),
    .PWM_PERIOD (PWM_PERIOD),
    .STEP_TICKS (STEP_TICKS),
    .LEVEL_STEP (LEVEL_STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sentido    (sentido),
    .mode       (mode),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .pwm_out    (pwm_out),
    .step_pulse (step_pulse),
    .head_idx   (head_idx)
  );

  int checks = 0;
  int errors = 0;

  // Model state: the duty ring, the buffered duties seen by the comparators, and the timing counters.
  int              mDuty   [N_CH];
  int              mActive [N_CH];
  int              mPeriod, mStep, mLevel, mHead;
  bit              mUp;
  logic [N_CH-1:0] mPwm;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N_CH; i++) begin
      mDuty[i]   = (i * LEVEL_STEP > PWM_PERIOD) ? PWM_PERIOD : i * LEVEL_STEP;
      mActive[i] = mDuty[i];
    end
    mPeriod = 0;
    mStep   = 0;
    mLevel  = 0;
    mUp     = 1'b1;
    mHead   = 0;
    mPwm    = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    int  old [N_CH];
    bit  wrapNow, tickNow;
    if (rst) begin
      modelReset();
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      mPwm[i] = en && (mPeriod < mActive[i]);
    end
    if (en) begin
      wrapNow = (mPeriod == PWM_PERIOD - 1);
      tickNow = (mStep == STEP_TICKS - 1);
      if (wrapNow) mActive = mDuty;
      mPeriod = wrapNow ? 0 : mPeriod + 1;
      mStep   = tickNow ? 0 : mStep + 1;
      if (tickNow) begin
        case (mode)
          2'd0: begin
            old = mDuty;
            for (int i = 0; i < N_CH; i++) begin
              mDuty[i] = sentido ? old[(i + N_CH - 1) % N_CH] : old[(i + 1) % N_CH];
            end
            mHead = sentido ? (mHead + 1) % N_CH : (mHead + N_CH - 1) % N_CH;
          end
          2'd1: begin
            if (mUp) begin
              mLevel = (mLevel + LEVEL_STEP >= PWM_PERIOD) ? PWM_PERIOD : mLevel + LEVEL_STEP;
              if (mLevel == PWM_PERIOD) mUp = 1'b0;
            end else begin
              mLevel = (mLevel - LEVEL_STEP <= 0) ? 0 : mLevel - LEVEL_STEP;
              if (mLevel == 0) mUp = 1'b1;
            end
            for (int i = 0; i < N_CH; i++) mDuty[i] = mLevel;
          end
          default: begin
          end
        endcase
      end
    end
    if (wr_en) mDuty[wr_ch] = (int'(wr_duty) > PWM_PERIOD) ? PWM_PERIOD : int'(wr_duty);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m, input logic s,
                               input logic we, input logic [1:0] wc, input logic [PWM_BITS-1:0] wd);
    rst     = r;
    en      = e;
    mode    = m;
    sentido = s;
    wr_en   = we;
    wr_ch   = wc;
    wr_duty = wd;
  endtask

  // Called at a negedge with inputs applied: compare, take the edge, update the model.
  task automatic runCycle();
    #1;
    checkOutput("pwm_out", 32'(pwm_out), 32'(mPwm));
    checkOutput("step_pulse", 32'(step_pulse), 32'(en && (mStep == STEP_TICKS - 1)));
    checkOutput("head_idx", 32'(head_idx), 32'(mHead));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, '0);
    runCycle();
  endtask

  int hiCount [N_CH];

  initial begin
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, '0);
    @(posedge clk);
    modelReset();
    @(negedge clk);

    // HOLD after reset: one full period shows the reset ramp 0,2,4,6.
    for (int i = 0; i < N_CH; i++) hiCount[i] = 0;
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, '0);
    for (int c = 0; c < PWM_PERIOD; c++) begin
      runCycle();
      for (int i = 0; i < N_CH; i++) hiCount[i] += int'(pwm_out[i]);
    end
    for (int i = 0; i < N_CH; i++) checkOutput($sformatf("hold_hi_ch%0d", i), 32'(hiCount[i]), 32'(2 * i));
    for (int c = 0; c < 20; c++) runCycle();

    // ROTATE toward index 0, then back the other way.
    resetCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, '0);
    for (int c = 0; c < STEP_TICKS; c++) runCycle();
    checkOutput("head_after_one_left", 32'(head_idx), 32'd3);
    for (int c = 0; c < 3 * STEP_TICKS; c++) runCycle();
    checkOutput("head_after_four_left", 32'(head_idx), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, '0);
    for (int c = 0; c < STEP_TICKS; c++) runCycle();
    checkOutput("head_after_one_right", 32'(head_idx), 32'd1);
    for (int c = 0; c < 25; c++) runCycle();

    // BREATHE from level 0 up to the saturated top and back down.
    resetCycle();
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, '0);
    for (int c = 0; c < 8 * STEP_TICKS; c++) runCycle();
    for (int c = 0; c < 3 * STEP_TICKS; c++) runCycle();

    // Saturating write landing on a rotate step edge.
    resetCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, '0);
    for (int c = 0; c < 30 && mStep != STEP_TICKS - 1; c++) runCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd2, 4'd15);
    runCycle();
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, '0);
    for (int c = 0; c < 2 * PWM_PERIOD; c++) runCycle();

    // Disable mid-period for seven cycles, with a write while disabled, then a reset pulse.
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, '0);
    for (int c = 0; c < 4; c++) runCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, '0);
    for (int c = 0; c < 7; c++) begin
      if (c == 3) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 4'd9);
      else        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, '0);
      runCycle();
      checkOutput("pwm_while_disabled", 32'(pwm_out), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, '0);
    for (int c = 0; c < 15; c++) runCycle();
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 2'd3, 4'd5);
    runCycle();
    checkOutput("head_after_rst", 32'(head_idx), 32'd0);
    checkOutput("pwm_after_rst", 32'(pwm_out), 32'd0);

    // Random traffic across modes, writes, enable gaps and occasional resets.
    for (int c = 0; c < 800; c++) begin
      logic [1:0] m;
      logic       s;
      m = mode;
      s = sentido;
      if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) s = ~s;
      applyStimulus(($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 9) != 0),
                    m, s,
                    ($urandom_range(0, 7) == 0),
                    2'($urandom_range(0, 3)),
                    PWM_BITS'($urandom_range(0, 15)));
      runCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_chaser.md
Name: pwm_chaser

Overview:
Parametrised N-channel PWM LED sequencer that drives a bank of LEDs with per-channel duty levels. Three modes:
- Rotate: the duty pattern circulates in the direction set by sentido.
- Breathe: all channels ramp together.
- Hold: the pattern is frozen.
Sits between board I/O (LEDR/LEDG) and top-level control switches. A host-side write port loads individual duties.

Parameters:
N_CH, 10, number of PWM channels (2..32)
PWM_BITS, 7, width of duty/period counter
PWM_PERIOD, 100, PWM period in clk cycles (<= 2**PWM_BITS - 1)
STEP_TICKS, 25000000, clk cycles between pattern steps
LEVEL_STEP, 10, reset duty increment per channel and breathe increment

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous to clk, active-high
en  in  1  1 = run; 0 = outputs forced low, all counters held
sentido  in  1  rotate direction: 0 = toward index 0, 1 = toward index N_CH-1
mode  in  2  0 ROTATE, 1 BREATHE, 2 HOLD, 3 reserved (treated as HOLD)
wr_en  in  1  single-cycle duty write strobe
wr_ch  in  $clog2(N_CH)  channel for write; wr_ch >= N_CH ignored
wr_duty  in  PWM_BITS  duty to write; values > PWM_PERIOD saturate to PWM_PERIOD
pwm_out  out  N_CH  registered PWM outputs
step_pulse  out  1  one-cycle pulse on each step tick
head_idx  out  $clog2(N_CH)  index of the channel currently holding original duty[0] (rotate tracking)

Behaviour:
- Reset (rst=1 at posedge) values:
  - period counter = 0, step counter = 0, head_idx = 0, pwm_out = 0, step_pulse = 0.
  - duty[i] = min(i*LEVEL_STEP, PWM_PERIOD); active_duty[i] = duty[i].
  - breathe level = 0, breathe direction = up.
- Period counter: counts 0..PWM_PERIOD-1 then wraps to 0.
- Output rule: pwm_out[i] is registered, one cycle after the counter value, and equals (period < active_duty[i]).
  - Duty 0 = never high.
  - Duty PWM_PERIOD = always high.
- Shadow update: active_duty[i] <= duty[i] only on the cycle the period counter wraps (PWM_PERIOD-1 -> 0). No mid-period glitches.
- Step counter: counts 0..STEP_TICKS-1. At terminal count it wraps and step_pulse=1 for that cycle. Step actions occur on the same edge.
- ROTATE step:
  - sentido=0: duty[i] <= duty[i+1] for i<N_CH-1; duty[N_CH-1] <= duty[0]; head_idx decrements modulo N_CH.
  - sentido=1: duty[i] <= duty[i-1] for i>0; duty[0] <= duty[N_CH-1]; head_idx increments modulo N_CH.
  - The full ring is preserved; no duty value is lost or duplicated.
- BREATHE step:
  - level +/- LEVEL_STEP, saturating at 0 and PWM_PERIOD.
  - On reaching a bound, direction flips for the next step.
  - Every duty[i] <= new level.
- HOLD step: duties unchanged; step_pulse still asserted.
- Mode change: sampled at each step tick only; counters not reset. Entering BREATHE keeps the current level/direction registers.
- Write port: when wr_en=1 and wr_ch valid, duty[wr_ch] <= saturated wr_duty.
  - Write coinciding with a step: the step applies to all channels, then the write overrides its channel (write wins).
  - Write takes visible effect at the next period wrap.
- en=0:
  - pwm_out forced 0 on the next edge.
  - Period and step counters hold; step_pulse 0.
  - Writes still accepted.
- rst mid-operation: all state returns to reset values on that edge regardless of en/wr_en.

Decomposition:
- Package pwm_chaser_pkg:
  - typedef enum logic[1:0] mode_e {MODE_ROTATE, MODE_BREATHE, MODE_HOLD, MODE_RSVD}.
  - Function sat_duty(value, max).
- Sub-module pwm_channel: holds active_duty, performs shadow load on wrap, compares against period, registers output. Instantiated N_CH times via generate.
- Top holds counters, duty ring, breathe FSM, write port.

Test Plan (N_CH=4, PWM_PERIOD=10, STEP_TICKS=5, LEVEL_STEP=2, PWM_BITS=4):
1. Reset then en=1, mode=HOLD -> duties 0,2,4,6. Over one 10-cycle period pwm_out[0..3] high for 0,2,4,6 cycles; pattern stable across steps.
2. mode=ROTATE, sentido=0, one step -> duties 2,4,6,0; head_idx 3. Four steps return to 0,2,4,6, head_idx 0.
3. mode=ROTATE, sentido=1, one step -> duties 6,0,2,4; head_idx 1. step_pulse high exactly one cycle per 5.
4. mode=BREATHE from level 0 -> levels 2,4,6,8,10,8,6 on successive steps; all channels equal. Duty 10 gives pwm_out constantly 1.
5. wr_en with wr_ch=2, wr_duty=15 on the same cycle as a rotate step -> duty[2]=10 (saturated, write wins). Output changes only after the next period wrap.
6. en=0 mid-period for 7 cycles -> pwm_out=0, counters frozen, resumes from the same count. rst pulse mid-run -> state matches scenario 1 start.
